// File: rtl/serializer_if.sv
// Word-in / bit-out bus of the serializer: the producer side (master) offers a word
// and a bit count, and the serializer side (slave) returns the serial bit stream and busy.
interface serializer_if #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) ();
  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              busy_o;

  modport master (
    output data_i, data_mod_i, data_val_i,
    input  ser_data_o, ser_data_val_o, busy_o
  );

  modport slave (
    input  data_i, data_mod_i, data_val_i,
    output ser_data_o, ser_data_val_o, busy_o
  );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first. Define SERIALIZER_LSB_FIRST_EN to send
// the word LSB first instead. Timing and length decoding are identical in both orders.
module serializer #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
) (
  input logic         clk_i,
  input logic         rst_ni,
  serializer_if.slave bus
);

  localparam int CNT_W = MOD_W + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ser_data_reg, ser_data_next;
  logic              ser_val_reg, ser_val_next;
  logic              busy_reg, busy_next;

  logic [DATA_W-1:0] data_ord;
  logic [CNT_W-1:0]  n_eff;
  logic              accept;

  // Both orders feed one left-shifting datapath: LSB-first just mirrors the word.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_order
`ifdef SERIALIZER_LSB_FIRST_EN
      assign data_ord[gi] = bus.data_i[DATA_W-1-gi];
`else
      assign data_ord[gi] = bus.data_i[gi];
`endif
    end
  endgenerate

  assign n_eff  = (bus.data_mod_i == '0) ? CNT_W'(DATA_W) : {1'b0, bus.data_mod_i};
  assign accept = bus.data_val_i && (n_eff >= CNT_W'(3));

  // cnt_reg holds the number of bits still to be sent after the one on the output.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    cnt_next      = cnt_reg;
    ser_data_next = ser_data_reg;
    ser_val_next  = ser_val_reg;
    busy_next     = busy_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next    = SHIFT;
          ser_data_next = data_ord[DATA_W-1];
          shift_next    = {data_ord[DATA_W-2:0], 1'b0};
          cnt_next      = n_eff - CNT_W'(1);
          ser_val_next  = 1'b1;
          busy_next     = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_reg == '0) begin
          state_next    = IDLE;
          shift_next    = '0;
          ser_data_next = 1'b0;
          ser_val_next  = 1'b0;
          busy_next     = 1'b0;
        end else begin
          ser_data_next = shift_reg[DATA_W-1];
          shift_next    = {shift_reg[DATA_W-2:0], 1'b0};
          cnt_next      = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        shift_next    = '0;
        cnt_next      = '0;
        ser_data_next = 1'b0;
        ser_val_next  = 1'b0;
        busy_next     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      ser_data_reg <= 1'b0;
      ser_val_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      cnt_reg      <= cnt_next;
      ser_data_reg <= ser_data_next;
      ser_val_reg  <= ser_val_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.ser_data_o     = ser_data_reg;
  assign bus.ser_data_val_o = ser_val_reg;
  assign bus.busy_o         = busy_reg;

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: stimulus queues hand-computed bits, an
// independent negedge monitor pops and compares every valid serial bit.
module tb_serializer;
  localparam int DATA_W = 16;
  localparam int MOD_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serializer_if #(.DATA_W(DATA_W), .MOD_W(MOD_W)) bus ();

  serializer #(.DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle, compare valid bits against the queue and idle invariants.
  always @(negedge clk) begin
    logic e;
    if (bus.ser_data_val_o) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_bit: got valid bit %0b, expected no output at %0t",
                 bus.ser_data_o, $time);
      end else begin
        e = exp_q.pop_front();
        check("ser_data", {31'b0, bus.ser_data_o}, {31'b0, e});
      end
    end else begin
      check("idle_data_zero", {31'b0, bus.ser_data_o}, 32'd0);
    end
    check("busy_eq_val", {31'b0, bus.busy_o}, {31'b0, bus.ser_data_val_o});
  end

  task automatic push_bits(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pat[15-i]);
  endtask

  // Returns one time unit after the capture edge.
  task automatic pulse(input logic [15:0] d, input logic [3:0] m);
    @(posedge clk);
    #1;
    bus.data_i     = d;
    bus.data_mod_i = m;
    bus.data_val_i = 1'b1;
    @(posedge clk);
    #1;
    bus.data_val_i = 1'b0;
    $display("[TB] request data=%h mod=%0d", d, m);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check(name, exp_q.size(), 32'd0);
    check({name, "_busy_low"}, {31'b0, bus.busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    bus.data_i     = '0;
    bus.data_mod_i = '0;
    bus.data_val_i = 1'b0;
    #12;
    check("reset_val",  {31'b0, bus.ser_data_val_o}, 32'd0);
    check("reset_busy", {31'b0, bus.busy_o}, 32'd0);
    check("reset_data", {31'b0, bus.ser_data_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full word, MSB first.
    push_bits(16'b1101_1010_1010_1100, 16);
    pulse(16'hDAAC, 4'd0);
    check("full_busy_first", {31'b0, bus.busy_o}, 32'd1);
    repeat (15) @(posedge clk);
    #1;
    check("full_busy_last", {31'b0, bus.busy_o}, 32'd1);
    @(posedge clk);
    #1;
    check("full_busy_end", {31'b0, bus.busy_o}, 32'd0);
    check("full_val_end", {31'b0, bus.ser_data_val_o}, 32'd0);
    drain("full_drain");

    // Partial word of 5 bits.
    push_bits(16'b1111_1000_0000_0000, 5);
    pulse(16'hFFFF, 4'd5);
    repeat (4) @(posedge clk);
    #1;
    check("part_val_5th", {31'b0, bus.ser_data_val_o}, 32'd1);
    @(posedge clk);
    #1;
    check("part_val_6th", {31'b0, bus.ser_data_val_o}, 32'd0);
    check("part_busy_6th", {31'b0, bus.busy_o}, 32'd0);
    drain("part_drain");

    // Lengths 1 and 2 are discarded.
    pulse(16'hFFFF, 4'd1);
    check("len1_busy", {31'b0, bus.busy_o}, 32'd0);
    pulse(16'hFFFF, 4'd2);
    check("len2_busy", {31'b0, bus.busy_o}, 32'd0);
    drain("ignored_drain");

    // Request while busy is dropped.
    push_bits(16'hF000, 16);
    pulse(16'hF000, 4'd0);
    repeat (4) @(posedge clk);
    #1;
    bus.data_i     = 16'h0FFF;
    bus.data_mod_i = 4'd0;
    bus.data_val_i = 1'b1;
    @(posedge clk);
    #1;
    bus.data_val_i = 1'b0;
    $display("[TB] request data=0fff mod=0 while busy");
    drain("busy_rej_drain");

    // Back-to-back with data_val_i held: period N+1 = 4.
    @(posedge clk);
    #1;
    bus.data_i     = 16'hA000;
    bus.data_mod_i = 4'd3;
    bus.data_val_i = 1'b1;
    for (int r = 0; r < 3; r++) push_bits(16'b1010_0000_0000_0000, 3);
    $display("[TB] request data=a000 mod=3 held for 12 cycles");
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b_val_pattern", {31'b0, bus.ser_data_val_o}, (i % 4 != 3) ? 32'd1 : 32'd0);
    end
    bus.data_val_i = 1'b0;
    drain("b2b_drain");

    // Reset during bit 7 aborts the transfer.
    push_bits(16'hFFFF, 16);
    pulse(16'hFFFF, 4'd0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_val",  {31'b0, bus.ser_data_val_o}, 32'd0);
    check("abort_busy", {31'b0, bus.busy_o}, 32'd0);
    check("abort_data", {31'b0, bus.ser_data_o}, 32'd0);
    check("abort_bits_seen", 32'(16 - exp_q.size()), 32'd7);
    exp_q.delete();
    $display("[TB] reset asserted mid-transfer");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_bits(16'h8001, 16);
    pulse(16'h8001, 4'd0);
    drain("post_reset_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter. Captures a DATA_W-bit word plus a valid-bit count in one cycle, then shifts the bits out one per clock, MSB first, with a qualifying valid strobe.
- Sits between a word-oriented producer and a single-bit serial link or encoder.
- busy_o provides flow control: the producer offers a word only while busy_o is low.

Parameters:
- DATA_W, 16, parallel word width; must be a power of two, at least 4.
- MOD_W, $clog2(DATA_W), width of the bit-count field (4 by default).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_ni  input  1  asynchronous reset, active-low.
- data_i  input  DATA_W  parallel word; bit DATA_W-1 is sent first.
- data_mod_i  input  MOD_W  number of bits to send; 0 means all DATA_W bits.
- data_val_i  input  1  word/count valid, sampled on the rising edge.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  ser_data_o is valid this cycle.
- busy_o  output  1  transfer in progress; new requests are ignored.

Behaviour:
- Reset: rst_ni low asynchronously forces state IDLE, ser_data_o=0, ser_data_val_o=0, busy_o=0, and clears the shift register and counter. Release is synchronous to clk_i; the first capture can happen on the first edge after release.
- States: IDLE and SHIFT.
- Effective length N = DATA_W when data_mod_i=0, otherwise data_mod_i.
- Capture rule: on an edge with state IDLE and data_val_i=1:
  - N is 1 or 2: the request is discarded, with no output activity and the state stays IDLE.
  - N is 3 or more: latch data_i and N, and go to SHIFT.
- Latency: on the capture edge, ser_data_o<=data_i[DATA_W-1], ser_data_val_o<=1 and busy_o<=1. The first bit is therefore valid in the cycle right after capture.
- SHIFT: on each following edge, output the next lower bit. The k-th output cycle (k=0..N-1) carries data_i[DATA_W-1-k] of the captured word. Exactly N consecutive valid cycles are produced, with no gaps.
- Termination: on the edge after the cycle carrying the last bit, ser_data_val_o<=0, busy_o<=0, ser_data_o<=0, and the state returns to IDLE.
- Outputs are fully registered.
- busy_o is high exactly during the N cycles in which ser_data_val_o is high.
- data_val_i and data_i are ignored while busy_o=1. A request pending at that time is neither queued nor merged.
- Back-to-back: a request on the edge where busy_o falls (first IDLE edge) is accepted. The minimum gap between transfers is one idle cycle.
- If data_val_i stays high continuously, a new capture occurs every N+1 cycles.
- ser_data_o is 0 whenever ser_data_val_o=0.
- Reset asserted mid-transfer aborts the transfer immediately with no further valid bits. The partial word is lost.
- Data bits below the N-th most significant bit are never sent.

Optional Feature:
- Macro SERIALIZER_LSB_FIRST_EN.
- Defined: bit order is reversed. The k-th output cycle carries data_i[k], so with N bits, data_i[0] through data_i[N-1] are sent. Timing, counting, data_mod_i decoding and busy behaviour are unchanged.
- Undefined: MSB-first order as specified in Behaviour.

Test Plan:
- Full word: after reset, data_i=16'hDAAC, data_mod_i=0, one-cycle data_val_i pulse -> 16 valid cycles with ser_data_o = 1,1,0,1,1,0,1,0,1,0,1,0,1,1,0,0. busy_o is high for those 16 cycles and low the cycle after; ser_data_val_o then falls.
- Partial word: data_i=16'hFFFF, data_mod_i=5 -> exactly 5 valid cycles of 1. busy_o and ser_data_val_o are low on the 6th cycle.
- Ignored lengths: data_mod_i=1, then data_mod_i=2, each with a data_val_i pulse -> ser_data_val_o and busy_o stay 0 throughout.
- Busy rejection: start a 16-bit transfer of 16'hF000, then pulse data_val_i with 16'h0FFF during cycle 5 -> the original 16 bits come out unchanged and no second transfer starts.
- Back-to-back: hold data_val_i=1 with data_mod_i=3 and data_i=16'hA000 -> a repeating pattern of 1,0,1 (valid) followed by 1 idle cycle, i.e. period 4.
- Reset mid-transfer: pull rst_ni low during bit 7 of a 16-bit transfer -> all outputs go to 0 asynchronously. After release, a fresh request of 16'h8001 with data_mod_i=0 yields a 1, fourteen 0s and a 1.
